flash_copy_dma: RTL and testbench

FLASH_COPY_DMA -- requirements
Module: flash_copy_dma

---
 rtl/flash_copy_dma.sv | 159 +++++++++++++++
 tb/tb_flash_copy_dma.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_copy_dma.sv
// Flash-to-memory word copy engine with a Wishbone master and a running checksum of the words it reads.
// Optional ack watchdog: define FLASH_COPY_DMA_TIMEOUT_EN (limit set by TIMEOUT).
module flash_copy_dma #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [31:0] src_adr,
    input  logic [31:0] dst_adr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] checksum,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    input  logic        wbm_ack_i,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  rst_sync;
    logic        rst_n_int;
    logic [29:0] src_ptr;
    logic [29:0] dst_ptr;
    logic [15:0] remain;
    logic [31:0] data_buf;
    logic        unused_ok;

    // Reset asserts immediately but releases only after two sys_clk edges.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    assign wbm_sel_o = 4'b1111;
    assign state_dbg = state;

`ifdef FLASH_COPY_DMA_TIMEOUT_EN
    logic       err_q;
    logic [7:0] tmo_cnt;
    assign err       = err_q;
    assign unused_ok = ^{src_adr[1:0], dst_adr[1:0]};
`else
    assign err       = 1'b0;
    assign unused_ok = ^{src_adr[1:0], dst_adr[1:0], TIMEOUT};
`endif

    // Bus handshake: a beat is offered while cyc&stb are high and completes on the
    // edge that sees ack with stb high; ack with stb low is ignored. Each state
    // spends its first cycle with stb low, so strobes are never back-to-back.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remain    <= '0;
            data_buf  <= '0;
`ifdef FLASH_COPY_DMA_TIMEOUT_EN
            err_q     <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr  <= src_adr[31:2];
                        dst_ptr  <= dst_adr[31:2];
                        remain   <= len;
                        checksum <= '0;
                        busy     <= 1'b1;
`ifdef FLASH_COPY_DMA_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                        state    <= (len == 16'd0) ? FIN : RD;
                    end
                end
                RD: begin
                    if (!wbm_stb_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        wbm_adr_o <= {src_ptr, 2'b00};
                    end else if (wbm_ack_i) begin
                        data_buf  <= wbm_dat_i;
                        checksum  <= checksum + wbm_dat_i;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= WR;
                    end
                end
                WR: begin
                    if (!wbm_stb_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        wbm_adr_o <= {dst_ptr, 2'b00};
                        wbm_dat_o <= data_buf;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        src_ptr   <= src_ptr + 30'd1;
                        dst_ptr   <= dst_ptr + 30'd1;
                        remain    <= remain - 16'd1;
                        state     <= (remain == 16'd1) ? FIN : RD;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef FLASH_COPY_DMA_TIMEOUT_EN
            // Watchdog: strobe stays up for exactly TIMEOUT cycles before the abort.
            if (wbm_stb_o && !wbm_ack_i) begin
                if (tmo_cnt == TIMEOUT - 8'd1) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_we_o  <= 1'b0;
                    err_q     <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= FIN;
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_flash_copy_dma.sv
// Directed bench for flash_copy_dma: a scripted Wishbone slave checks every bus beat
// against an expected queue and supplies read data; summary line at the end.
module tb_flash_copy_dma;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic [31:0] src_adr;
    logic [31:0] dst_adr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic        wbm_ack_i;
    logic [1:0]  state_dbg;

    // Expected bus beats: {we, adr, dat}; for reads dat is what the slave returns.
    logic [64:0] exp_q[$];
    logic [64:0] cur_e;

    int checks;
    int errors;
    int ack_wait;
    int no_ack;
    int wait_cnt;
    int done_cnt;
    int cyc_cycles;
    int stb_cycles;
    int b2b_cnt;
    int d0;
    int c0;
    int s0;

    flash_copy_dma #(.TIMEOUT(8'd20)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .src_adr   (src_adr),
        .dst_adr   (dst_adr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_o (wbm_sel_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_ack_i (wbm_ack_i),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_rd(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({1'b0, a, d});
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge sys_clk);
        src_adr = s;
        dst_adr = d;
        len     = n;
        start   = 1'b1;
        @(negedge sys_clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check("done_seen", {64'b0, done}, 65'd1);
        @(negedge sys_clk);
    endtask

    // Slave + monitors: act on the falling edge, away from the DUT's sampling edge.
    always @(negedge sys_clk) begin
        if (wbm_ack_i && wbm_stb_o) b2b_cnt++;
        if (wbm_cyc_o) cyc_cycles++;
        if (wbm_stb_o) stb_cycles++;
        if (done)      done_cnt++;
        if (wbm_ack_i || !(wbm_cyc_o && wbm_stb_o)) begin
            wbm_ack_i = 1'b0;
            wait_cnt  = 0;
        end else if (no_ack == 0) begin
            wait_cnt++;
            if (wait_cnt >= ack_wait) begin
                if (exp_q.size() == 0) begin
                    check("bus_unexpected", {wbm_we_o, wbm_adr_o, wbm_dat_o}, '1);
                end else begin
                    cur_e = exp_q.pop_front();
                    check("bus_we_adr", {32'b0, wbm_we_o, wbm_adr_o}, {32'b0, cur_e[64:32]});
                    if (wbm_we_o) check("bus_wr_dat", {33'b0, wbm_dat_o}, {33'b0, cur_e[31:0]});
                    else          wbm_dat_i = cur_e[31:0];
                end
                wbm_ack_i = 1'b1;
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        ack_wait   = 7;
        no_ack     = 0;
        wait_cnt   = 0;
        done_cnt   = 0;
        cyc_cycles = 0;
        stb_cycles = 0;
        b2b_cnt    = 0;
        start      = 1'b0;
        src_adr    = '0;
        dst_adr    = '0;
        len        = '0;
        wbm_dat_i  = '0;
        wbm_ack_i  = 1'b0;
        sys_rst_n  = 1'b1;
        #2 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Reset values
        check("rst_busy",  {64'b0, busy},      65'd0);
        check("rst_done",  {64'b0, done},      65'd0);
        check("rst_err",   {64'b0, err},       65'd0);
        check("rst_csum",  {33'b0, checksum},  65'd0);
        check("rst_cyc",   {64'b0, wbm_cyc_o}, 65'd0);
        check("rst_stb",   {64'b0, wbm_stb_o}, 65'd0);
        check("rst_we",    {64'b0, wbm_we_o},  65'd0);
        check("rst_adr",   {33'b0, wbm_adr_o}, 65'd0);
        check("rst_dat",   {33'b0, wbm_dat_o}, 65'd0);
        check("rst_state", {63'b0, state_dbg}, 65'd0);
        check("sel_const", {61'b0, wbm_sel_o}, 65'hF);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Three-word copy, slave waits 7 cycles per beat
        ack_wait = 7;
        push_rd(32'h0000_1000, 32'd1); push_wr(32'h4000_0000, 32'd1);
        push_rd(32'h0000_1004, 32'd2); push_wr(32'h4000_0004, 32'd2);
        push_rd(32'h0000_1008, 32'd3); push_wr(32'h4000_0008, 32'd3);
        d0 = done_cnt;
        start_copy(32'h0000_1000, 32'h4000_0000, 16'd3);
        check("cp3_busy", {64'b0, busy}, 65'd1);
        wait_done(400);
        check("cp3_csum",  {33'b0, checksum}, 65'd6);
        check("cp3_err",   {64'b0, err},      65'd0);
        check("cp3_dones", done_cnt - d0,     65'd1);
        check("cp3_left",  exp_q.size(),      65'd0);
        check("cp3_idle",  {64'b0, busy},     65'd0);

        // Zero-length copy: no bus cycle, busy for one cycle, done two cycles after start
        c0 = cyc_cycles;
        d0 = done_cnt;
        @(negedge sys_clk);
        src_adr = 32'h0000_0040; dst_adr = 32'h0000_0080; len = 16'd0; start = 1'b1;
        @(posedge sys_clk); #1 start = 1'b0;
        check("z_busy1", {64'b0, busy}, 65'd1);
        check("z_done1", {64'b0, done}, 65'd0);
        @(posedge sys_clk); #1;
        check("z_done2", {64'b0, done}, 65'd1);
        check("z_busy2", {64'b0, busy}, 65'd0);
        @(posedge sys_clk); #1;
        check("z_done3", {64'b0, done}, 65'd0);
        @(negedge sys_clk);
        check("z_nocyc", cyc_cycles - c0, 65'd0);
        check("z_dones", done_cnt - d0,   65'd1);

        // Start while busy is ignored; low address bits are dropped
        ack_wait = 3;
        push_rd(32'h0000_2000, 32'h11); push_wr(32'h0000_5000, 32'h11);
        push_rd(32'h0000_2004, 32'h22); push_wr(32'h0000_5004, 32'h22);
        d0 = done_cnt;
        start_copy(32'h0000_2003, 32'h0000_5002, 16'd2);
        repeat (4) @(negedge sys_clk);
        start_copy(32'h0000_9000, 32'h0000_A000, 16'd7);
        wait_done(400);
        check("ign_csum",  {33'b0, checksum}, 65'h33);
        check("ign_dones", done_cnt - d0,     65'd1);
        check("ign_left",  exp_q.size(),      65'd0);

        // Checksum wraps and the source pointer wraps past the top of the address space
        ack_wait = 2;
        push_rd(32'hFFFF_FFFC, 32'hFFFF_FFFF); push_wr(32'h0000_3000, 32'hFFFF_FFFF);
        push_rd(32'h0000_0000, 32'h0000_0002); push_wr(32'h0000_3004, 32'h0000_0002);
        start_copy(32'hFFFF_FFFC, 32'h0000_3000, 16'd2);
        wait_done(400);
        check("wrap_csum", {33'b0, checksum}, 65'd1);
        check("wrap_left", exp_q.size(),      65'd0);

        // Reset during a write beat, then a normal single-word copy
        ack_wait = 5;
        push_rd(32'h0000_7000, 32'h5A5A_5A5A); push_wr(32'h0000_8000, 32'h5A5A_5A5A);
        start_copy(32'h0000_7000, 32'h0000_8000, 16'd2);
        begin
            int n;
            n = 0;
            while (!(wbm_stb_o && wbm_we_o) && n < 200) begin
                @(negedge sys_clk);
                n++;
            end
        end
        check("rst_in_wr", {64'b0, wbm_stb_o && wbm_we_o}, 65'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("mid_cyc",   {64'b0, wbm_cyc_o}, 65'd0);
        check("mid_stb",   {64'b0, wbm_stb_o}, 65'd0);
        check("mid_we",    {64'b0, wbm_we_o},  65'd0);
        check("mid_busy",  {64'b0, busy},      65'd0);
        check("mid_state", {63'b0, state_dbg}, 65'd0);
        exp_q.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        check("post_busy", {64'b0, busy}, 65'd0);
        push_rd(32'h0000_3000, 32'hABCD_0123); push_wr(32'h0000_6000, 32'hABCD_0123);
        d0 = done_cnt;
        start_copy(32'h0000_3000, 32'h0000_6000, 16'd1);
        wait_done(200);
        check("post_csum",  {33'b0, checksum}, 65'hABCD_0123);
        check("post_dones", done_cnt - d0,     65'd1);
        check("post_left",  exp_q.size(),      65'd0);

`ifdef FLASH_COPY_DMA_TIMEOUT_EN
        // Slave never acks: watchdog aborts after 20 strobe cycles
        no_ack = 1;
        s0 = stb_cycles;
        d0 = done_cnt;
        start_copy(32'h0000_0100, 32'h0000_0200, 16'd1);
        wait_done(200);
        repeat (3) @(negedge sys_clk);
        check("tmo_stb",   stb_cycles - s0,    65'd20);
        check("tmo_err",   {64'b0, err},       65'd1);
        check("tmo_dones", done_cnt - d0,      65'd1);
        check("tmo_csum",  {33'b0, checksum},  65'd0);
        check("tmo_cyc",   {64'b0, wbm_cyc_o}, 65'd0);
        no_ack = 0;
        push_rd(32'h0000_0100, 32'h0000_0007); push_wr(32'h0000_0200, 32'h0000_0007);
        start_copy(32'h0000_0100, 32'h0000_0200, 16'd1);
        wait_done(200);
        check("tmo_errclr", {64'b0, err},      65'd0);
        check("tmo_csum2",  {33'b0, checksum}, 65'd7);
`endif

        check("no_b2b", b2b_cnt, 65'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
